// File: rtl/fp16_pkg.sv
// Shared FP16 types, constants and helpers for the reduction datapath.
package fp16_pkg;

    typedef logic [15:0] fp16_t;

    localparam fp16_t FP16_QNAN    = 16'h7E00;
    localparam fp16_t FP16_POS_INF = 16'h7C00;
    localparam fp16_t FP16_ZERO    = 16'h0000;
    localparam int unsigned EXP_LEN  = 5;
    localparam int unsigned MANT_LEN = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    function automatic logic is_nan(input fp16_t v);
        return (&v[14:MANT_LEN]) && (|v[MANT_LEN-1:0]);
    endfunction

endpackage

// File: rtl/float16_adder.sv
// Combinational FP16 adder with round-to-nearest-even, gradual underflow and
// IEEE special-value handling; NaN results are always the canonical quiet NaN.
module float16_adder
    import fp16_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum
);

    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic        w_swap, w_eff_sub, w_found, w_rnd;
    fp16_t       w_big, w_small;
    logic [5:0]  w_e_big, w_e_small, w_diff, w_e_n, w_e_f, w_lz, w_limit, w_shl;
    logic [4:0]  w_sh;
    logic [13:0] w_m_big, w_m_small, w_m_al, w_norm;
    logic [27:0] w_wide;
    logic [14:0] w_s15;
    logic [11:0] w_mr;
    logic [9:0]  w_mant;
    fp16_t       w_res;

    assign w_a_nan = is_nan(i_a);
    assign w_b_nan = is_nan(i_b);
    assign w_a_inf = (i_a[14:0] == FP16_POS_INF[14:0]);
    assign w_b_inf = (i_b[14:0] == FP16_POS_INF[14:0]);

    always_comb begin
        w_swap    = (i_b[14:0] > i_a[14:0]);
        w_big     = w_swap ? i_b : i_a;
        w_small   = w_swap ? i_a : i_b;
        w_e_big   = (w_big[14:MANT_LEN] == '0) ? 6'd1 : {1'b0, w_big[14:MANT_LEN]};
        w_e_small = (w_small[14:MANT_LEN] == '0) ? 6'd1 : {1'b0, w_small[14:MANT_LEN]};
        w_m_big   = {(w_big[14:MANT_LEN] != '0), w_big[MANT_LEN-1:0], 3'b000};
        w_m_small = {(w_small[14:MANT_LEN] != '0), w_small[MANT_LEN-1:0], 3'b000};
        w_diff    = w_e_big - w_e_small;
        w_sh      = (w_diff > 6'd16) ? 5'd16 : w_diff[4:0];

        // Align the smaller operand; everything shifted past the round bit
        // collapses into the sticky bit.
        w_wide    = {w_m_small, 14'b0} >> w_sh;
        w_m_al    = {w_wide[27:15], w_wide[14] | (|w_wide[13:0])};
        w_eff_sub = w_big[15] ^ w_small[15];
        w_s15     = w_eff_sub ? ({1'b0, w_m_big} - {1'b0, w_m_al})
                              : ({1'b0, w_m_big} + {1'b0, w_m_al});

        w_lz    = 6'd0;
        w_found = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (!w_found && w_s15[i]) begin
                w_lz    = 6'(13 - i);
                w_found = 1'b1;
            end
        end
        w_limit = w_e_big - 6'd1;
        w_shl   = 6'd0;

        if (w_s15[14]) begin
            w_norm = {w_s15[14:2], w_s15[1] | w_s15[0]};
            w_e_n  = w_e_big + 6'd1;
        end else begin
            // Stop normalising at the minimum exponent so tiny results go subnormal.
            w_shl  = (w_lz > w_limit) ? w_limit : w_lz;
            w_norm = w_s15[13:0] << w_shl;
            w_e_n  = w_e_big - w_shl;
        end

        w_rnd = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mr  = {1'b0, w_norm[13:3]} + {11'b0, w_rnd};
        if (w_mr[11]) begin
            w_e_f  = w_e_n + 6'd1;
            w_mant = '0;
        end else begin
            w_e_f  = w_mr[10] ? w_e_n : 6'd0;
            w_mant = w_mr[9:0];
        end

        if (w_e_f >= 6'd31) begin
            w_res = {w_big[15], FP16_POS_INF[14:0]};
        end else begin
            w_res = {w_big[15], w_e_f[EXP_LEN-1:0], w_mant};
        end

        if (w_s15 == '0) begin
            w_res = {w_big[15] & w_small[15], FP16_ZERO[14:0]};
        end

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[15] != i_b[15]))) begin
            o_sum = FP16_QNAN;
        end else if (w_a_inf) begin
            o_sum = i_a;
        end else if (w_b_inf) begin
            o_sum = i_b;
        end else begin
            o_sum = w_res;
        end
    end

endmodule

// File: rtl/float16_accumulator.sv
// Streams FP16 operands into a registered accumulator through one adder and
// presents the sum and a saturating element count once per vector.
module float16_accumulator
    import fp16_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned FLOAT_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLOAT_LEN-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FLOAT_LEN-1:0] out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_nan
);

    acc_state_t       r_state, w_state_next;
    fp16_t            r_acc, w_acc_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    fp16_t            w_add_sum;
    logic             w_in_fire, w_out_fire;

    float16_adder u_adder (
        .i_a   (r_acc),
        .i_b   (in_data),
        .o_sum (w_add_sum)
    );

    assign in_ready   = (r_state != DONE);
    assign out_valid  = (r_state == DONE);
    assign out_sum    = r_acc;
    assign out_count  = r_cnt;
    assign out_nan    = is_nan(r_acc);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            IDLE: begin
                // First element bypasses the adder so -0 and subnormals are kept exact.
                if (w_in_fire) begin
                    w_acc_next   = in_data;
                    w_cnt_next   = {{(CNT_W-1){1'b0}}, 1'b1};
                    w_state_next = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (w_in_fire) begin
                    w_acc_next = w_add_sum;
                    w_cnt_next = w_cnt_inc;
                    if (in_last) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (w_out_fire) begin
                    w_acc_next   = FP16_ZERO;
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_acc_next   = FP16_ZERO;
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= FP16_ZERO;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
        end
    end

endmodule

// File: tb/tb_float16_accumulator.sv
// Directed bench for float16_accumulator with hand-computed FP16 sums.
module tb_float16_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [7:0]  out_count;
    logic        out_nan;

    int errors = 0;
    int checks = 0;

    float16_accumulator #(
        .CNT_W     (8),
        .FLOAT_LEN (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_nan   (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offers one element and holds it until it transfers (bounded).
    task automatic push(input logic [15:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 50) check_eq("push_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [15:0] sum,
                                 input logic [7:0] cnt, input logic nan);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_sum"}, 32'(out_sum), 32'(sum));
        check_eq({tag, "_count"}, 32'(out_count), 32'(cnt));
        check_eq({tag, "_nan"}, 32'(out_nan), 32'(nan));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_drained"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_ready_again"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sum", 32'(out_sum), 32'h0);
        check_eq("rst_count", 32'(out_count), 32'd0);
        check_eq("rst_nan", 32'(out_nan), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // 1 + 2 + 3 = 6, back-to-back; result valid right after the last edge
        push(16'h3C00, 1'b0);
        push(16'h4000, 1'b0);
        push(16'h4200, 1'b1);
        expect_result("sum3", 16'h4600, 8'd3, 1'b0);

        push(16'hC500, 1'b1);
        expect_result("single_neg", 16'hC500, 8'd1, 1'b0);
        push(16'h8000, 1'b1);
        expect_result("neg_zero", 16'h8000, 8'd1, 1'b0);

        push(16'h7C00, 1'b0);
        push(16'hFC00, 1'b1);
        expect_result("inf_minus_inf", 16'h7E00, 8'd2, 1'b1);
        push(16'h7E01, 1'b0);
        push(16'h3C00, 1'b1);
        expect_result("nan_prop", 16'h7E00, 8'd2, 1'b1);

        // Idle gap with a stray in_last while in_valid is low
        push(16'h3C00, 1'b0);
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_last = 1'b0;
        check_eq("gap_no_done", 32'(out_valid), 32'd0);
        push(16'h3C00, 1'b1);
        expect_result("gap_sum", 16'h4000, 8'd2, 1'b0);

        // 2048 + 1 + 1: each tie rounds to even mantissa, staying at 2048
        push(16'h6800, 1'b0);
        push(16'h3C00, 1'b0);
        push(16'h3C00, 1'b1);
        expect_result("rne_down", 16'h6800, 8'd3, 1'b0);
        // 2050 + 1: tie rounds up to 2052
        push(16'h6801, 1'b0);
        push(16'h3C00, 1'b1);
        expect_result("rne_up", 16'h6802, 8'd2, 1'b0);
        push(16'h4200, 1'b0);
        push(16'hC200, 1'b1);
        expect_result("cancel", 16'h0000, 8'd2, 1'b0);

        // 300 x 1.0 = 300.0 (0x5CB0); count saturates at 255
        for (int i = 0; i < 299; i++) push(16'h3C00, 1'b0);
        push(16'h3C00, 1'b1);
        expect_result("sat300", 16'h5CB0, 8'd255, 1'b0);

        // Output back-pressure with input still offered
        push(16'h3C00, 1'b0);
        push(16'h4000, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h4400;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_sum", 32'(out_sum), 32'h4200);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        expect_result("stall_release", 16'h4200, 8'd2, 1'b0);
        push(16'h4400, 1'b1);
        expect_result("after_stall", 16'h4400, 8'd1, 1'b0);

        // Asynchronous reset mid-vector discards the partial sum
        push(16'h3C00, 1'b0);
        push(16'h4000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_count", 32'(out_count), 32'd0);
        check_eq("arst_sum", 32'(out_sum), 32'h0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        push(16'h4000, 1'b1);
        expect_result("post_reset", 16'h4000, 8'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
